ws2812_driver: RTL and testbench
================================

// Module: ws2812_driver
//
// PURPOSE
//   Serialises one RGB colour (three 8-bit levels, as produced by the encoder stage) into the
//   single-wire WS2812 NRZ protocol, so the mixer can drive an addressable LED strip.
//   Sits downstream of the encoders, alongside the per-channel pwm blocks.
//   Every frame repeats the same colour LED_COUNT times, then holds the latch gap.
//
// PARAMETERS
//   LED_COUNT  1    pixels per frame; the same GRB word is sent LED_COUNT times (>=1)
//   T0H_CYC    5    clk cycles dout is high for a '0' bit (0.42 us @ 12 MHz)
//   T1H_CYC    10   clk cycles dout is high for a '1' bit (0.83 us @ 12 MHz)
//   TBIT_CYC   15   clk cycles per bit period (1.25 us @ 12 MHz)
//   TRST_CYC   720  clk cycles dout is held low after a frame (latch gap, 60 us @ 12 MHz)
//   Constraint: 0 < T0H_CYC < T1H_CYC < TBIT_CYC and TRST_CYC >= 1.
//   A violation is an elaboration-time error.
//
// PORTS
//   clk      in   1  system clock; all state is on the rising edge
//   reset    in   1  asynchronous, active-low reset
//   red      in   8  red level; sampled only on accept
//   green    in   8  green level; sampled only on accept
//   blue     in   8  blue level; sampled only on accept
//   valid    in   1  new colour is available
//   ready    out  1  block is able to accept a colour (high only in IDLE)
//   busy     out  1  high while in SEND
//   dout     out  1  WS2812 data line, registered
//
// BEHAVIOUR
// States
//   - States: LATCH, IDLE, SEND.
//   - While reset is low: state=LATCH, all counters 0, dout=0, ready=0, busy=0.
//   - After reset deasserts, the block stays in LATCH for TRST_CYC cycles, so a frame truncated
//     by reset is always terminated before a new frame starts.
//   - IDLE: ready=1, dout=0.
//     Accept = valid & ready at a rising edge; the block captures word = {green, red, blue}.
//     The block then goes to SEND with bit_idx=23, pix_cnt=0, phase=0.
//   - SEND: the bit is b = word[bit_idx], sent MSB first (G7 first, B0 last).
//     - dout=1 while phase < (b ? T1H_CYC : T0H_CYC); otherwise dout=0.
//     - phase counts 0..TBIT_CYC-1.
//     - At wrap, bit_idx decrements.
//     - At bit_idx 0 wrap, bit_idx reloads 23 and pix_cnt increments.
//     - After the last bit of pixel LED_COUNT-1, the block goes to LATCH with phase cleared.
//   - LATCH: dout=0 for exactly TRST_CYC cycles, then IDLE.
// Timing
//   - Latency: dout rises in the first cycle after the accept edge.
//     SEND lasts LED_COUNT*24*TBIT_CYC cycles.
//     Reset defaults: SEND = 360 cycles; ready re-asserts 360+720+1 = 1081 cycles after accept.
//   - Counter widths: $clog2 of each maximum.
//     No counter wraps except as specified above; pix_cnt never exceeds LED_COUNT-1.
// Boundary cases
//   - valid may stay high. A new accept happens only in IDLE; back-to-back frames are separated
//     by exactly one IDLE cycle.
//   - Input changes after accept are ignored until the next accept.
//   - Reset mid-SEND: dout drops to 0 asynchronously and the remaining bits are discarded.
//     The block re-enters via LATCH.
//   - LED_COUNT=1 with T0H_CYC=1 must still give a 1-cycle high pulse.
//
// TESTING
//   1. Release reset, valid=0 -> ready=0 for 720 cycles, then ready=1 and dout=0 throughout.
//   2. Accept R=0x00 G=0xFF B=0x00 -> 8 pulses high for 10 cycles, then 16 pulses high for
//      5 cycles, each in a 15-cycle period; ready returns 1081 cycles after accept.
//   3. Accept R=0xA5 G=0x3C B=0x81 -> the decoded bit stream equals 0x3CA581, MSB first.
//   4. LED_COUNT=3, accept 0x123456 (G,R,B) -> the 72-bit stream is the word repeated 3 times,
//      followed by a 720-cycle low gap.
//   5. Hold valid=1 and change the inputs mid-frame -> the frame carries the originally
//      captured word; the next frame starts one IDLE cycle after LATCH and carries the new values.
//   6. Pull reset low at bit 10 of a frame -> dout=0 immediately; after release, no accept for
//      720 cycles.

Source files
------------

// File: rtl/ws2812_driver.sv
// WS2812 single-wire NRZ serialiser: sends one {G,R,B} word LED_COUNT times per frame,
// then holds the line low for the latch gap before accepting the next colour.
module ws2812_driver #(
   parameter int LED_COUNT = 1,
   parameter int T0H_CYC   = 5,
   parameter int T1H_CYC   = 10,
   parameter int TBIT_CYC  = 15,
   parameter int TRST_CYC  = 720
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] red,
   input  logic [7:0] green,
   input  logic [7:0] blue,
   input  logic       valid,
   output logic       ready,
   output logic       busy,
   output logic       dout
);

   localparam int PH_W  = $clog2(TBIT_CYC);
   localparam int PIX_W = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
   localparam int LAT_W = (TRST_CYC > 1) ? $clog2(TRST_CYC) : 1;

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(TBIT_CYC - 1);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(LED_COUNT - 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(TRST_CYC - 1);

   if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC &&
         TRST_CYC >= 1 && LED_COUNT >= 1)) begin : g_param_check
      $error("ws2812_driver: invalid timing parameters");
   end

   typedef enum logic [1:0] {LATCH, IDLE, SEND} state_t;

   state_t            state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [4:0]        bit_q, bit_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [23:0]       word_q, word_d;
   logic              dout_q, dout_d;
   logic              accept;

   function automatic logic [PH_W-1:0] high_len(input logic b);
      return b ? PH_W'(T1H_CYC) : PH_W'(T0H_CYC);
   endfunction

   assign accept = (state_q == IDLE) && valid;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      pix_d   = pix_q;
      lat_d   = lat_q;
      word_d  = accept ? {green, red, blue} : word_q;
      case (state_q)
         LATCH: begin
            if (lat_q == LAT_LAST) begin
               state_d = IDLE;
               lat_d   = '0;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         IDLE: begin
            if (valid) begin
               state_d = SEND;
               phase_d = '0;
               bit_d   = 5'd23;
               pix_d   = '0;
            end
         end
         SEND: begin
            if (phase_q == PH_LAST) begin
               phase_d = '0;
               if (bit_q == 5'd0) begin
                  bit_d = 5'd23;
                  if (pix_q == PIX_LAST) begin
                     state_d = LATCH;
                     pix_d   = '0;
                     lat_d   = '0;
                  end else begin
                     pix_d = pix_q + 1'b1;
                  end
               end else begin
                  bit_d = bit_q - 1'b1;
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         default: state_d = LATCH;
      endcase
      // dout is computed from next-state values so the registered line tracks phase with no lag
      dout_d = (state_d == SEND) && (phase_d < high_len(word_d[bit_d]));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= LATCH;
         phase_q <= '0;
         bit_q   <= '0;
         pix_q   <= '0;
         lat_q   <= '0;
         dout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         pix_q   <= pix_d;
         lat_q   <= lat_d;
         dout_q  <= dout_d;
      end
   end

   // colour word is pure data; it is only ever read after an accept has loaded it
   always_ff @(posedge clk) begin
      word_q <= word_d;
   end

   assign ready = (state_q == IDLE);
   assign busy  = (state_q == SEND);
   assign dout  = dout_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// Bench for ws2812_driver: three instances (default, 3 pixels, minimum timings) with a
// pulse-decoding monitor that checks every pulse against a scoreboard of expected bits.
module tb_ws2812_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst [3];
   logic [7:0] r [3];
   logic [7:0] g [3];
   logic [7:0] b [3];
   logic       vld [3];
   logic       rdy [3];
   logic       bsy [3];
   logic       dq  [3];

   int LEDN [3] = '{1, 3, 1};
   int T0   [3] = '{5, 5, 1};
   int T1   [3] = '{10, 10, 2};
   int TB   [3] = '{15, 15, 3};
   int TR   [3] = '{720, 720, 4};

   ws2812_driver dut_a (
      .clk(clk), .reset(rst[0]), .red(r[0]), .green(g[0]), .blue(b[0]),
      .valid(vld[0]), .ready(rdy[0]), .busy(bsy[0]), .dout(dq[0]));

   ws2812_driver #(.LED_COUNT(3)) dut_b (
      .clk(clk), .reset(rst[1]), .red(r[1]), .green(g[1]), .blue(b[1]),
      .valid(vld[1]), .ready(rdy[1]), .busy(bsy[1]), .dout(dq[1]));

   ws2812_driver #(.LED_COUNT(1), .T0H_CYC(1), .T1H_CYC(2), .TBIT_CYC(3), .TRST_CYC(4)) dut_c (
      .clk(clk), .reset(rst[2]), .red(r[2]), .green(g[2]), .blue(b[2]),
      .valid(vld[2]), .ready(rdy[2]), .busy(bsy[2]), .dout(dq[2]));

   typedef struct {
      int hi;
      int gap;
   } pulse_t;

   typedef struct {
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
      logic [23:0] word;
   } vec_t;

   pulse_t sb [3][$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // pulse decoder: high length of every pulse and rise-to-rise spacing within a frame
   int cyc = 0;
   bit mon_en [3];
   bit prev [3];
   int hl [3];
   int last_rise [3];

   always @(negedge clk) begin
      pulse_t e;
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (!mon_en[i]) begin
            prev[i] = 1'b0;
            hl[i]   = 0;
         end else if (dq[i] === 1'b1) begin
            if (!prev[i]) begin
               if (sb[i].size() > 0 && sb[i][0].gap != 0)
                  check($sformatf("bit_period%0d", i), cyc - last_rise[i], sb[i][0].gap);
               last_rise[i] = cyc;
            end
            hl[i]++;
            prev[i] = 1'b1;
         end else begin
            if (prev[i]) begin
               if (sb[i].size() == 0) begin
                  check($sformatf("extra_pulse%0d", i), 1, 0);
               end else begin
                  e = sb[i].pop_front();
                  check($sformatf("pulse_high%0d", i), hl[i], e.hi);
               end
               hl[i] = 0;
            end
            prev[i] = 1'b0;
         end
      end
   end

   task automatic push_frame(input int i, input logic [23:0] word);
      pulse_t e;
      for (int px = 0; px < LEDN[i]; px++) begin
         for (int bi = 23; bi >= 0; bi--) begin
            e.hi  = word[bi] ? T1[i] : T0[i];
            e.gap = (px == 0 && bi == 23) ? 0 : TB[i];
            sb[i].push_back(e);
         end
      end
   endtask

   // release reset right after an edge and count the LATCH cycles before ready
   task automatic release_rst(input int i);
      int n;
      @(posedge clk);
      #1 rst[i] = 1'b1;
      n = 0;
      @(negedge clk);
      while (rdy[i] !== 1'b1 && n < 3000) begin
         n++;
         check($sformatf("latch_dout%0d", i), dq[i], 0);
         @(negedge clk);
      end
      check($sformatf("reset_latch_len%0d", i), n, TR[i]);
   endtask

   task automatic accept(input int i, input logic [7:0] rr, input logic [7:0] gg,
                         input logic [7:0] bb, input logic [23:0] word, input bit hold);
      int n;
      n = 0;
      @(negedge clk);
      while (rdy[i] !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("accept_ready%0d", i), rdy[i], 1);
      r[i] = rr; g[i] = gg; b[i] = bb; vld[i] = 1'b1;
      push_frame(i, word);
      @(posedge clk);
      #1;
      r[i] = 8'($urandom); g[i] = 8'($urandom); b[i] = 8'($urandom);
      if (!hold) vld[i] = 1'b0;
   endtask

   // cycle 1 is the one right after the accept edge; ready must be back in cycle 1081
   task automatic wait_frame(input int i);
      int n, nb, nl;
      n = 0; nb = 0; nl = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            check($sformatf("first_dout%0d", i), dq[i], 1);
            check($sformatf("busy_start%0d", i), bsy[i], 1);
         end
         if (bsy[i] === 1'b1) nb++;
         else if (dq[i] !== 1'b0) nl++;
      end while (rdy[i] !== 1'b1 && n < 5000);
      check($sformatf("ready_return%0d", i), n, LEDN[i] * 24 * TB[i] + TR[i] + 1);
      check($sformatf("busy_len%0d", i), nb, LEDN[i] * 24 * TB[i]);
      check($sformatf("gap_low%0d", i), nl, 0);
      check($sformatf("sb_empty%0d", i), sb[i].size(), 0);
   endtask

   vec_t tbl [5];

   initial begin
      tbl[0] = '{8'h00, 8'hFF, 8'h00, 24'hFF0000};
      tbl[1] = '{8'hA5, 8'h3C, 8'h81, 24'h3CA581};
      tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF};
      tbl[3] = '{8'h00, 8'h00, 8'h00, 24'h000000};
      tbl[4] = '{8'h01, 8'h80, 8'h7E, 24'h80017E};

      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b0; vld[i] = 1'b0;
         r[i] = 8'h00; g[i] = 8'h00; b[i] = 8'h00;
         mon_en[i] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_ready%0d", i), rdy[i], 0);
         check($sformatf("rst_busy%0d", i), bsy[i], 0);
         check($sformatf("rst_dout%0d", i), dq[i], 0);
      end

      for (int i = 0; i < 3; i++) release_rst(i);

      for (int k = 0; k < 5; k++) begin
         accept(0, tbl[k].r, tbl[k].g, tbl[k].b, tbl[k].word, 1'b0);
         wait_frame(0);
      end

      accept(1, 8'h34, 8'h12, 8'h56, 24'h123456, 1'b0);
      wait_frame(1);

      accept(2, 8'h0F, 8'hF0, 8'h55, 24'hF00F55, 1'b0);
      wait_frame(2);

      // valid held high: inputs change mid-frame, next frame follows after one IDLE cycle
      accept(0, 8'h11, 8'h22, 8'h33, 24'h221133, 1'b1);
      r[0] = 8'h44; g[0] = 8'h55; b[0] = 8'h66;
      wait_frame(0);
      push_frame(0, 24'h554466);
      @(posedge clk);
      #1 vld[0] = 1'b0;
      wait_frame(0);

      // reset in the high part of bit 10
      accept(0, 8'hC3, 8'h5A, 8'hE7, 24'h5AC3E7, 1'b0);
      repeat (152) @(negedge clk);
      mon_en[0] = 1'b0;
      check("pre_reset_dout", dq[0], 1);
      #1 rst[0] = 1'b0;
      #1;
      check("async_dout", dq[0], 0);
      check("async_ready", rdy[0], 0);
      check("async_busy", bsy[0], 0);
      sb[0].delete();
      repeat (3) @(posedge clk);
      mon_en[0] = 1'b1;
      r[0] = 8'h0A; g[0] = 8'hB0; b[0] = 8'hC5; vld[0] = 1'b1;
      release_rst(0);
      push_frame(0, 24'hB00AC5);
      @(posedge clk);
      #1 vld[0] = 1'b0;
      wait_frame(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

endmodule
